periph_bus_arbiter: RTL and testbench

- Shares the single peripheral-bus master port (the address/data/mask/select decode path to data memory and UART) between two requesters.
- Requester 0 is the core load/store stage. Requester 1 is a secondary master (UART boot loader / DMA).
- Grants round-robin on contention and holds the bus for the owner until the slave completes or a watchdog expires.
- Sits between the requesters and the peripheral bus decode.

---
 rtl/periph_arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 29 ++
 rtl/periph_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
//   state_e   : arbiter FSM state (IDLE / BUSY)
//   owner_t   : 1-bit requester id (0 = core load/store, 1 = boot loader / DMA)
//   ERR_RDATA : read data returned on a watchdog timeout completion
package periph_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef logic owner_t;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick.
// Ports:
//   req        : request vector, bit i = requester i
//   last_owner : requester that most recently completed; loses a tie
//   gnt        : one-hot grant, or zero when nobody requests
//   winner     : id of the granted requester (don't-care when gnt == 0)
module rr_pick2
    import periph_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic [1:0] gnt,
    output owner_t     winner
);

    always_comb begin
        winner = 1'b0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else begin
            winner = req[1];
        end
        if (req != 2'b00) begin
            gnt = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the peripheral-bus master port between the core load/store stage
// (m0) and a secondary master (m1). Round-robin on contention; the owner
// holds the bus until the slave signals ready or the watchdog expires.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   m{0,1}_req/we/addr/wdata/mask_i : request and its attributes (held until gnt)
//   m{0,1}_gnt_o              : request accepted this cycle (combinational)
//   m{0,1}_rvalid_o, _err_o   : one-cycle completion pulse, err = timeout
//   rdata_o                   : shared load data, held until the next completion
//   bus_valid/we/addr/wdata/mask_o : transaction presented to the peripheral bus
//   bus_rdata_i, bus_ready_i  : slave response
//
// state | meaning
// IDLE  | no transaction outstanding; gnt follows req combinationally
// BUSY  | bus_* presented and held; waiting for ready or watchdog
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [DW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic [3:0]    m0_mask_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic          m0_err_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [DW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    input  logic [3:0]    m1_mask_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic          m1_err_o,
    output logic [DW-1:0] rdata_o,
    output logic          bus_valid_o,
    output logic          bus_we_o,
    output logic [DW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    output logic [3:0]    bus_mask_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_ready_i
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] ERR_WORD = DW'(ERR_RDATA);

    state_e        state_q, state_d;
    owner_t        owner_q, last_owner_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    pick_gnt;
    owner_t        pick_winner;
    logic          grant, done_ok, done_to, done;

    rr_pick2 u_pick (
        .req        ({m1_req_i, m0_req_i}),
        .last_owner (last_owner_q),
        .gnt        (pick_gnt),
        .winner     (pick_winner)
    );

    assign grant   = (state_q == IDLE) && (pick_gnt != 2'b00);
    // Ready wins over the watchdog when both land in the same cycle.
    assign done_ok = (state_q == BUSY) && bus_ready_i;
    assign done_to = (state_q == BUSY) && !bus_ready_i && (cnt_q == CNT_LAST);
    assign done    = done_ok || done_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        bus_valid_o = 1'b0;
        if (state_q == IDLE) begin
            m0_gnt_o = pick_gnt[0];
            m1_gnt_o = pick_gnt[1];
        end else begin
            bus_valid_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_mask_o   <= '0;
            m0_rvalid_o  <= 1'b0;
            m1_rvalid_o  <= 1'b0;
            m0_err_o     <= 1'b0;
            m1_err_o     <= 1'b0;
            rdata_o      <= '0;
        end else begin
            m0_rvalid_o <= done && (owner_q == 1'b0);
            m1_rvalid_o <= done && (owner_q == 1'b1);
            m0_err_o    <= done_to && (owner_q == 1'b0);
            m1_err_o    <= done_to && (owner_q == 1'b1);

            if (grant) begin
                owner_q     <= pick_winner;
                bus_we_o    <= pick_winner ? m1_we_i    : m0_we_i;
                bus_addr_o  <= pick_winner ? m1_addr_i  : m0_addr_i;
                bus_wdata_o <= pick_winner ? m1_wdata_i : m0_wdata_i;
                bus_mask_o  <= pick_winner ? m1_mask_i  : m0_mask_i;
            end

            if (done) begin
                cnt_q        <= '0;
                last_owner_q <= owner_q;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (done_ok) begin
                rdata_o <= bus_we_o ? '0 : bus_rdata_i;
            end else if (done_to) begin
                rdata_o <= ERR_WORD;
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
module tb_periph_bus_arbiter;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [DW-1:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]    m0_mask_i, m1_mask_i;
    logic          m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [DW-1:0] rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic          bus_valid_o, bus_we_o, bus_ready_i;
    logic [3:0]    bus_mask_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_mask_i(m0_mask_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_mask_i(m1_mask_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_err_o(m1_err_o),
        .rdata_o(rdata_o), .bus_valid_o(bus_valid_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_mask_o(bus_mask_o),
        .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i)
    );

    task automatic clear_inputs();
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0; m0_mask_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0; m1_mask_i = '0;
        bus_rdata_i = '0; bus_ready_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #1;
        checks++; if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, bus_valid_o, bus_we_o} !== 8'h00) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, bus_valid_o, bus_we_o}); end
        checks++; if ({rdata_o, bus_addr_o, bus_wdata_o, bus_mask_o} !== '0) begin
            failures++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h mask=%h exp=0", rdata_o, bus_addr_o, bus_wdata_o, bus_mask_o); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_m0_load();
        do_reset();
        @(posedge clk); #1;
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h104; m0_mask_i = 4'hF;
        bus_ready_i = 1; bus_rdata_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            failures++; $display("FAIL m0_load_gnt got=%b exp=10", {m0_gnt_o, m1_gnt_o}); end
        @(posedge clk); #1;
        m0_req_i = 0;
        @(negedge clk);
        checks++; if (bus_valid_o !== 1'b1 || bus_addr_o !== 32'h104 || bus_we_o !== 1'b0 || m0_gnt_o !== 1'b0) begin
            failures++; $display("FAIL m0_load_bus got valid=%b addr=%h we=%b gnt=%b exp 1/104/0/0", bus_valid_o, bus_addr_o, bus_we_o, m0_gnt_o); end
        @(posedge clk); #1;
        bus_ready_i = 0;
        @(negedge clk);
        checks++; if (m0_rvalid_o !== 1'b1 || m0_err_o !== 1'b0 || m1_rvalid_o !== 1'b0 || rdata_o !== 32'h1234_5678 || bus_valid_o !== 1'b0) begin
            failures++; $display("FAIL m0_load_done got rv=%b err=%b rv1=%b rdata=%h valid=%b exp 1/0/0/12345678/0", m0_rvalid_o, m0_err_o, m1_rvalid_o, rdata_o, bus_valid_o); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m0_rvalid_o !== 1'b0 || rdata_o !== 32'h1234_5678) begin
            failures++; $display("FAIL m0_load_hold got rv=%b rdata=%h exp 0/12345678", m0_rvalid_o, rdata_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(posedge clk); #1;
        m0_req_i = 1; m0_addr_i = 32'hA0; m1_req_i = 1; m1_addr_i = 32'hA1;
        bus_ready_i = 1; bus_rdata_i = 32'h1111_1111;
        @(negedge clk);
        checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            failures++; $display("FAIL tie1_gnt got=%b exp=10", {m0_gnt_o, m1_gnt_o}); end
        @(posedge clk); #1;
        m0_req_i = 0;
        @(negedge clk);
        checks++; if (bus_valid_o !== 1'b1 || bus_addr_o !== 32'hA0 || m1_gnt_o !== 1'b0) begin
            failures++; $display("FAIL tie1_bus got valid=%b addr=%h gnt1=%b exp 1/a0/0", bus_valid_o, bus_addr_o, m1_gnt_o); end
        @(posedge clk); #1;
        bus_rdata_i = 32'h2222_2222;
        @(negedge clk);
        checks++; if (m0_rvalid_o !== 1'b1 || rdata_o !== 32'h1111_1111 || {m0_gnt_o, m1_gnt_o} !== 2'b01) begin
            failures++; $display("FAIL tie2_overlap got rv0=%b rdata=%h gnt=%b exp 1/11111111/01", m0_rvalid_o, rdata_o, {m0_gnt_o, m1_gnt_o}); end
        @(posedge clk); #1;
        m1_addr_i = 32'hA2; m0_req_i = 1; m0_addr_i = 32'hA3;
        @(negedge clk);
        checks++; if (bus_addr_o !== 32'hA1 || {m0_gnt_o, m1_gnt_o} !== 2'b00) begin
            failures++; $display("FAIL tie2_bus got addr=%h gnt=%b exp a1/00", bus_addr_o, {m0_gnt_o, m1_gnt_o}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m1_rvalid_o !== 1'b1 || rdata_o !== 32'h2222_2222 || {m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            failures++; $display("FAIL tie3_gnt got rv1=%b rdata=%h gnt=%b exp 1/22222222/10", m1_rvalid_o, rdata_o, {m0_gnt_o, m1_gnt_o}); end
    endtask

    task automatic test_m1_store();
        do_reset();
        @(posedge clk); #1;
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h200; m1_wdata_i = 32'hA5A5_A5A5; m1_mask_i = 4'b0011;
        bus_rdata_i = 32'hFFFF_0000;
        @(negedge clk);
        checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
            failures++; $display("FAIL store_gnt got=%b exp=01", {m0_gnt_o, m1_gnt_o}); end
        @(posedge clk); #1;
        m1_req_i = 0; m1_wdata_i = '0; m1_mask_i = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i == 3) bus_ready_i = 1;
            @(negedge clk);
            checks++; if (bus_valid_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h200 || bus_wdata_o !== 32'hA5A5_A5A5 || bus_mask_o !== 4'b0011 || m1_rvalid_o !== 1'b0 || m0_rvalid_o !== 1'b0) begin
                failures++; $display("FAIL store_hold[%0d] got v=%b we=%b a=%h d=%h m=%b rv=%b%b exp 1/1/200/a5a5a5a5/0011/00", i, bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o, m0_rvalid_o, m1_rvalid_o); end
        end
        @(posedge clk); #1;
        bus_ready_i = 0;
        @(negedge clk);
        checks++; if (m1_rvalid_o !== 1'b1 || m1_err_o !== 1'b0 || rdata_o !== 32'h0 || m0_rvalid_o !== 1'b0 || m0_gnt_o !== 1'b0 || bus_valid_o !== 1'b0) begin
            failures++; $display("FAIL store_done got rv1=%b err1=%b rdata=%h rv0=%b gnt0=%b valid=%b exp 1/0/0/0/0/0", m1_rvalid_o, m1_err_o, rdata_o, m0_rvalid_o, m0_gnt_o, bus_valid_o); end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        @(posedge clk); #1;
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h300; bus_rdata_i = 32'h5555_5555;
        @(negedge clk);
        checks++; if (m0_gnt_o !== 1'b1) begin
            failures++; $display("FAIL to_gnt got=%b exp=1", m0_gnt_o); end
        @(posedge clk); #1;
        m0_req_i = 0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_valid_o === 1'b1) cnt++;
            else break;
        end
        checks++; if (cnt !== TO) begin
            failures++; $display("FAIL to_valid_len got=%0d exp=%0d", cnt, TO); end
        checks++; if (m0_rvalid_o !== 1'b1 || m0_err_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || m1_err_o !== 1'b0) begin
            failures++; $display("FAIL to_done got rv=%b err=%b rdata=%h err1=%b exp 1/1/deadbeef/0", m0_rvalid_o, m0_err_o, rdata_o, m1_err_o); end
        @(posedge clk); #1;
        m0_req_i = 1; m0_addr_i = 32'h304;
        @(negedge clk);
        checks++; if (m0_gnt_o !== 1'b1 || m0_err_o !== 1'b0) begin
            failures++; $display("FAIL to_next_gnt got gnt=%b err=%b exp 1/0", m0_gnt_o, m0_err_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        m0_req_i = 1; m0_addr_i = 32'h10; bus_ready_i = 1; bus_rdata_i = 32'h0BAD_F00D;
        @(posedge clk); #1;
        m0_req_i = 0;
        @(posedge clk); #1;
        bus_ready_i = 0; m1_req_i = 1; m1_addr_i = 32'h20;
        @(posedge clk); #1;
        m1_req_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_valid_o !== 1'b1 || bus_addr_o !== 32'h20 || rdata_o !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL rstmid_pre got valid=%b addr=%h rdata=%h exp 1/20/0badf00d", bus_valid_o, bus_addr_o, rdata_o); end
        #2;
        rst = 1;
        #1;
        checks++; if ({bus_valid_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 7'b0 || rdata_o !== '0 || bus_addr_o !== '0) begin
            failures++; $display("FAIL rstmid_async got ctrl=%b rdata=%h addr=%h exp 0", {bus_valid_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}, rdata_o, bus_addr_o); end
        @(negedge clk);
        rst = 0; bus_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin
                failures++; $display("FAIL rstmid_no_rvalid[%0d] got rv=%b%b exp 00", i, m0_rvalid_o, m1_rvalid_o); end
        end
        @(posedge clk); #1;
        m0_req_i = 1; m1_req_i = 1;
        @(negedge clk);
        checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
            failures++; $display("FAIL rstmid_tie got=%b exp=10", {m0_gnt_o, m1_gnt_o}); end
    endtask

    // Reference model: one outstanding transaction at most; arbitration by
    // "other than last completer"; completion seen one cycle after ready or
    // after the TO-th presented cycle.
    task automatic test_random();
        bit mb = 0, mo = 0, ml = 1;
        int mage = 0, drought = 0;
        logic cwe = 0; logic [31:0] ca = 0, cd = 0; logic [3:0] cm = 0;
        bit ev0 = 0, ev1 = 0, ee0 = 0, ee1 = 0, eg0, eg1, nv0, nv1, ne0, ne1;
        logic [31:0] erd = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            eg0 = !mb && m0_req_i && (!m1_req_i || ml);
            eg1 = !mb && m1_req_i && (!m0_req_i || !ml);
            checks++; if ({m0_gnt_o, m1_gnt_o} !== {eg0, eg1}) begin
                failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {m0_gnt_o, m1_gnt_o}, {eg0, eg1}); end
            checks++; if (bus_valid_o !== mb || (mb && (bus_we_o !== cwe || bus_addr_o !== ca || bus_wdata_o !== cd || bus_mask_o !== cm))) begin
                failures++; $display("FAIL rnd_bus cyc=%0d got v=%b we=%b a=%h d=%h m=%h exp v=%b we=%b a=%h d=%h m=%h", cyc, bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_mask_o, mb, cwe, ca, cd, cm); end
            checks++; if ({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== {ev0, ev1, ee0, ee1} || rdata_o !== erd) begin
                failures++; $display("FAIL rnd_resp cyc=%0d got rv=%b%b err=%b%b rdata=%h exp rv=%b%b err=%b%b rdata=%h", cyc, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o, rdata_o, ev0, ev1, ee0, ee1, erd); end
            nv0 = 0; nv1 = 0; ne0 = 0; ne1 = 0;
            if (!mb) begin
                if (eg0 || eg1) begin
                    mb = 1; mo = eg1; mage = 0;
                    cwe = eg1 ? m1_we_i : m0_we_i;
                    ca  = eg1 ? m1_addr_i : m0_addr_i;
                    cd  = eg1 ? m1_wdata_i : m0_wdata_i;
                    cm  = eg1 ? m1_mask_i : m0_mask_i;
                end
            end else if (bus_ready_i || mage == TO - 1) begin
                if (mo) begin nv1 = 1; ne1 = !bus_ready_i; end
                else    begin nv0 = 1; ne0 = !bus_ready_i; end
                erd = bus_ready_i ? (cwe ? 32'h0 : bus_rdata_i) : 32'hDEAD_BEEF;
                ml = mo; mb = 0;
            end else begin
                mage++;
            end
            ev0 = nv0; ev1 = nv1; ee0 = ne0; ee1 = ne1;
            @(posedge clk); #1;
            if (eg0) m0_req_i = 0;
            if (eg1) m1_req_i = 0;
            if (!m0_req_i && $urandom_range(0, 1) == 1) begin
                m0_req_i = 1; m0_we_i = 1'($urandom_range(0, 1)); m0_addr_i = $urandom;
                m0_wdata_i = $urandom; m0_mask_i = 4'($urandom_range(0, 15));
            end
            if (!m1_req_i && $urandom_range(0, 1) == 1) begin
                m1_req_i = 1; m1_we_i = 1'($urandom_range(0, 1)); m1_addr_i = $urandom;
                m1_wdata_i = $urandom; m1_mask_i = 4'($urandom_range(0, 15));
            end
            if (drought == 0 && $urandom_range(0, 40) == 0) drought = 20;
            if (drought > 0) begin bus_ready_i = 0; drought--; end
            else bus_ready_i = ($urandom_range(0, 2) == 0);
            bus_rdata_i = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_m0_load();
        test_back_to_back();
        test_m1_store();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
